// File: rtl/st_packets_to_bytes_t2h.sv
// rtl/st_packets_to_bytes_t2h.sv - t2h Avalon-ST packet beats to escaped in-band byte stream.
// Each beat is held and emitted as [CHAN ch] [SOP] [EOP] data with escaping of 0x7A..0x7D.
module st_packets_to_bytes_t2h #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic       in_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [7:0] in_channel,
    input  logic       in_startofpacket,
    input  logic       in_endofpacket,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data
);

    localparam logic [7:0] SOP_C  = 8'h7A;
    localparam logic [7:0] EOP_C  = 8'h7B;
    localparam logic [7:0] CHAN_C = 8'h7C;
    localparam logic [7:0] ESC_C  = 8'h7D;
    localparam logic [7:0] CHAN_MASK = 8'((9'h1 << CHANNEL_WIDTH) - 9'h1);

    typedef enum logic [2:0] {
        IDLE, CH_CHAR, CH_ESC, CH_BYTE, SOP_CHAR, EOP_CHAR, D_ESC, D_BYTE
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [7:0] chan_q, chan_d;
    logic       sop_q, sop_d;
    logic       eop_q, eop_d;
    logic       chan_sent_q, chan_sent_d;
    logic [7:0] last_chan_q, last_chan_d;
    logic       out_valid_q;
    logic [7:0] out_data_q, out_data_d;
    logic       consume;
    logic       accept;
    logic [7:0] chan_in;

    function automatic logic is_special(input logic [7:0] b);
        return (b >= SOP_C) && (b <= ESC_C);
    endfunction

    function automatic state_e data_state(input logic [7:0] d);
        return is_special(d) ? D_ESC : D_BYTE;
    endfunction

    // First state following the channel header (or the beat start if no header is needed).
    function automatic state_e after_chan(input logic s, input logic e, input logic [7:0] d);
        if (s)
            return SOP_CHAR;
        else if (e)
            return EOP_CHAR;
        return data_state(d);
    endfunction

    assign consume   = (state_q != IDLE) && out_ready;
    assign in_ready  = (state_q == IDLE) || ((state_q == D_BYTE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign chan_in   = in_channel & CHAN_MASK;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        chan_d      = chan_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        chan_sent_d = chan_sent_q;
        last_chan_d = last_chan_q;

        if (consume) begin
            case (state_q)
                CH_CHAR:  state_d = is_special(chan_q) ? CH_ESC : CH_BYTE;
                CH_ESC:   state_d = CH_BYTE;
                CH_BYTE: begin
                    state_d     = after_chan(sop_q, eop_q, data_q);
                    chan_sent_d = 1'b1;
                    last_chan_d = chan_q;
                end
                SOP_CHAR: state_d = eop_q ? EOP_CHAR : data_state(data_q);
                EOP_CHAR: state_d = data_state(data_q);
                D_ESC:    state_d = D_BYTE;
                D_BYTE:   state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end

        // Channel state is already settled here: a held beat's CH_BYTE precedes its D_BYTE.
        if (accept) begin
            data_d = in_data;
            chan_d = chan_in;
            sop_d  = in_startofpacket;
            eop_d  = in_endofpacket;
            if (!chan_sent_q || (chan_in != last_chan_q))
                state_d = CH_CHAR;
            else
                state_d = after_chan(in_startofpacket, in_endofpacket, in_data);
        end

        out_data_d = 8'h00;
        case (state_d)
            CH_CHAR:  out_data_d = CHAN_C;
            CH_ESC:   out_data_d = ESC_C;
            CH_BYTE:  out_data_d = is_special(chan_d) ? (chan_d ^ 8'h20) : chan_d;
            SOP_CHAR: out_data_d = SOP_C;
            EOP_CHAR: out_data_d = EOP_C;
            D_ESC:    out_data_d = ESC_C;
            D_BYTE:   out_data_d = is_special(data_d) ? (data_d ^ 8'h20) : data_d;
            default:  out_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= 8'h00;
            chan_q      <= 8'h00;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            chan_sent_q <= 1'b0;
            last_chan_q <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            chan_q      <= chan_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            chan_sent_q <= chan_sent_d;
            last_chan_q <= last_chan_d;
            out_valid_q <= (state_d != IDLE);
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_st_packets_to_bytes_t2h.sv
// tb/tb_st_packets_to_bytes_t2h.sv - scoreboard bench for st_packets_to_bytes_t2h.
module tb_st_packets_to_bytes_t2h;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_ready;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] in_channel = 8'h00;
    logic       in_startofpacket = 1'b0;
    logic       in_endofpacket = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;

    int         n_vec = 0;
    int         n_err = 0;
    int         pops = 0;
    bit         rnd = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] sb_q[$];

    st_packets_to_bytes_t2h #(.CHANNEL_WIDTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_ready         (in_ready),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_channel       (in_channel),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_bytes(input logic [7:0] b[]);
        foreach (b[i]) sb_q.push_back(b[i]);
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: inputs are driven just after posedge, so the negedge sees what the next edge will use.
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(stall_data));
            end
            if (out_valid && out_ready) begin
                chk("sb_avail", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) chk("byte", 32'(out_data), 32'(sb_q.pop_front()));
                pops++;
            end
            stalled    = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] ch, input logic s, input logic e,
                        input logic [7:0] d, output int waits);
        in_valid = 1'b1; in_channel = ch; in_startofpacket = s;
        in_endofpacket = e; in_data = d;
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int cnt;
        int p0;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Single framed beat on channel 0
        expect_bytes('{8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h41});
        send(8'd0, 1'b1, 1'b1, 8'h41, w);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
        end
        chk("ready_low_cycles", 32'(cnt), 32'd4);
        drain();

        // Three-beat packet on channel 2, no bubbles after the header
        expect_bytes('{8'h7C, 8'h02, 8'h7A, 8'h11, 8'h22, 8'h7B, 8'h33});
        send(8'd2, 1'b1, 1'b0, 8'h11, w);
        send(8'd2, 1'b0, 1'b0, 8'h22, w);
        chk("beat2_wait", 32'(w), 32'd3);
        send(8'd2, 1'b0, 1'b1, 8'h33, w);
        chk("beat3_wait", 32'(w), 32'd0);
        drain();

        // Escaping of data and channel bytes
        expect_bytes('{8'h7D, 8'h5D});
        send(8'd2, 1'b0, 1'b0, 8'h7D, w);
        expect_bytes('{8'h7C, 8'h7D, 8'h5A, 8'h7A, 8'h01});
        send(8'h7A, 1'b1, 1'b0, 8'h01, w);
        expect_bytes('{8'h7B, 8'h7D, 8'h5B});
        send(8'h7A, 1'b0, 1'b1, 8'h7B, w);
        drain();

        // Channel switch
        expect_bytes('{8'h7C, 8'h01, 8'h7A, 8'h7B, 8'hAA});
        send(8'd1, 1'b1, 1'b1, 8'hAA, w);
        expect_bytes('{8'h7A, 8'h7B, 8'hBB});
        send(8'd1, 1'b1, 1'b1, 8'hBB, w);
        expect_bytes('{8'h7C, 8'h03, 8'h7A, 8'h7B, 8'hCC});
        send(8'd3, 1'b1, 1'b1, 8'hCC, w);
        drain();

        // Random backpressure
        rnd = 1'b1;
        expect_bytes('{8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h41});
        send(8'd0, 1'b1, 1'b1, 8'h41, w);
        for (int k = 0; k < 6; k++) begin
            expect_bytes('{8'h7A, 8'h7B, 8'h41});
            send(8'd0, 1'b1, 1'b1, 8'h41, w);
        end
        expect_bytes('{8'h7C, 8'h04, 8'h7A, 8'h7D, 8'h5C, 8'h7B, 8'h7D, 8'h5A});
        send(8'd4, 1'b1, 1'b0, 8'h7C, w);
        send(8'd4, 1'b0, 1'b1, 8'h7A, w);
        drain();
        rnd = 1'b0;
        @(posedge clk); #1;

        // Reset mid-header with the beat still held
        p0 = pops;
        expect_bytes('{8'h7C, 8'h05, 8'h7A, 8'h10});
        send(8'd5, 1'b1, 1'b0, 8'h10, w);
        for (int i = 0; i < 50 && pops == p0; i++) @(negedge clk);
        chk("mid_first_pop", 32'(pops - p0), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        expect_bytes('{8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h55});
        send(8'd0, 1'b1, 1'b1, 8'h55, w);
        drain();
        repeat (3) @(negedge clk);
        chk("idle_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/st_packets_to_bytes_t2h.md
Name: st_packets_to_bytes_t2h

Overview:
- Serialises the trace-to-host Avalon-ST packet stream into a flat byte stream for the host byte link.
- Sits directly downstream of the t2h channel adapter, which supplies 8-bit data, an 8-bit channel, SOP and EOP.
- Encodes packet boundaries and channel changes in-band using reserved control characters, with an escape mechanism for payload bytes that collide with them.
- Output is a ready/valid byte stream with no channel or packet sideband.

Parameters:
- CHANNEL_WIDTH, 8, number of significant bits of in_channel (1..8); upper bits are ignored and compared as zero.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- in_ready  output  1  sink ready for a packet beat
- in_valid  input  1  beat valid
- in_data  input  8  payload byte
- in_channel  input  8  channel of the beat
- in_startofpacket  input  1  first beat of packet
- in_endofpacket  input  1  last beat of packet
- out_ready  input  1  downstream ready
- out_valid  output  1  output byte valid (registered)
- out_data  output  8  encoded byte (registered)

Behaviour:
- Control characters:
  - SOP = 0x7A, EOP = 0x7B, CHAN = 0x7C, ESC = 0x7D.
  - A "special" byte is any value in 0x7A..0x7D.
  - A special byte is transmitted as ESC followed by (byte XOR 0x20).
- Per accepted beat, the encoder emits this sequence in order:
  - (a) CHAN, then the channel byte (escaped if special). Emitted only if the channel differs from last_channel, or no channel has been sent since reset.
  - (b) SOP, if in_startofpacket.
  - (c) EOP, if in_endofpacket.
  - (d) the data byte, escaped if special.
- A beat therefore produces 1 to 7 output bytes.
- Channel tracking:
  - last_channel and the flag chan_sent are updated when CHAN's channel byte is emitted.
  - Both are cleared by reset.
- Holding register:
  - On in_valid && in_ready, data, channel, SOP and EOP are captured into the hold register.
  - The first output byte appears on out_valid in the next cycle (latency 1).
- in_ready is combinational and is high when either:
  - the hold register is empty; or
  - the byte currently presented is the final byte (d) of the held beat and out_ready = 1. This gives back-to-back throughput of 1 byte/cycle for unescaped data on an unchanged channel.
- Output handshake:
  - A byte is consumed when out_valid && out_ready.
  - While out_valid = 1 && out_ready = 0, out_data holds stable.
  - out_valid never drops without consumption.
- State machine (one state per byte type):
  - States: IDLE, CH_CHAR, CH_ESC, CH_BYTE, SOP_CHAR, EOP_CHAR, D_ESC, D_BYTE.
  - IDLE → the first applicable state on capture.
  - Each state advances on consumption to the next applicable state, skipping inapplicable steps.
  - D_BYTE advances to the first state of a newly captured beat, or to IDLE when none is captured.
  - The ESC states precede their corresponding byte states.
- Packet-level rules:
  - SOP and EOP on the same beat emit SOP_CHAR then EOP_CHAR.
  - A beat with neither SOP nor EOP emits data only.
  - No packet-framing check is performed; malformed framing passes through encoded as is.
- Reset (asynchronous, any time, including mid-sequence):
  - out_valid = 0, out_data = 0x00, state = IDLE, hold register empty, chan_sent = 0, last_channel = 0.
  - A partially emitted beat is discarded.
  - in_ready is high in the first cycle after reset release.
- Channel comparison covers bits [CHANNEL_WIDTH-1:0] only. The emitted channel byte is zero-extended from those bits.

Test Plan:
- Reset release, single beat {ch=0, sop=1, eop=1, data=0x41} → out bytes 7C 00 7A 7B 41; in_ready low until the 0x41 byte is consumed.
- Packet on ch=2: beats 0x11 (sop), 0x22, 0x33 (eop), out_ready held 1 → 7C 02 7A 11 22 7B 33; the 0x22 beat is accepted the cycle its predecessor's data byte is consumed (no bubbles after the header).
- Escaping: data 0x7D mid-packet → 7D 5D; channel 0x7A on a first beat with sop → 7C 7D 5A 7A followed by data.
- Channel switch: ch=1 packet {0xAA sop/eop}, then ch=1 packet {0xBB sop/eop}, then ch=3 packet {0xCC sop/eop} → 7C 01 7A 7B AA, 7A 7B BB, 7C 03 7A 7B CC.
- Backpressure: out_ready toggled randomly during the first scenario → identical byte order, out_data stable while stalled, no drops or duplicates.
- Reset asserted after 7C has been consumed mid-header, with the beat still held → outputs clear immediately; after release a new beat {ch=0, sop, eop, 0x55} yields 7C 00 7A 7B 55 (chan_sent was cleared).
